// File: rtl/spi32_arbiter_if.sv
// Signal bundle between the requesters, the spi32_arbiter and the spi32 core.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi32_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [2*NREQ-1:0]  req_nbytes;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_err;
    logic [31:0]        rsp_data;
    logic               spi_read;
    logic               spi_write;
    logic [31:0]        spi_din;
    logic [1:0]         spi_nbytes;
    logic               spi_busy;
    logic [31:0]        spi_dout;
    logic               spi_cs;
    logic [NREQ-1:0]    dev_cs;

    modport slave (
        input  req_valid, req_write, req_nbytes, req_data, spi_busy, spi_dout, spi_cs,
        output req_ready, rsp_valid, rsp_err, rsp_data, spi_read, spi_write, spi_din,
               spi_nbytes, dev_cs
    );

    modport master (
        output req_valid, req_write, req_nbytes, req_data, spi_busy, spi_dout, spi_cs,
        input  req_ready, rsp_valid, rsp_err, rsp_data, spi_read, spi_write, spi_din,
               spi_nbytes, dev_cs
    );
endinterface

// File: rtl/spi32_arbiter.sv
// Round-robin arbiter sharing one spi32 core among NREQ requesters; sequences each transfer
// on spi32 busy, returns the result to the winner and steers cs to the granted device.
module spi32_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned START_TMO = 15
) (
    input logic            clk,
    input logic            reset_n,
    spi32_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NREQ);
    localparam logic [NREQ-1:0] One = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone,
        StResp
    } state_e;

    state_e          state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] pick;
    logic            pick_valid;
    logic [7:0]      start_cnt;

    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IdxW-1:0];
    endfunction

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_valid && bus.req_valid[wrap_idx(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick       = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            rr_ptr         <= '0;
            grant          <= '0;
            start_cnt      <= '0;
            bus.req_ready  <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_data   <= '0;
            bus.spi_read   <= 1'b0;
            bus.spi_write  <= 1'b0;
            bus.spi_din    <= '0;
            bus.spi_nbytes <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.spi_read  <= 1'b0;
            bus.spi_write <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Command pulse is launched here so it is visible during the ISSUE cycle.
                    if (pick_valid) begin
                        grant          <= pick;
                        bus.spi_din    <= bus.req_data[32*pick +: 32];
                        bus.spi_nbytes <= bus.req_nbytes[2*pick +: 2];
                        bus.spi_write  <= bus.req_write[pick];
                        bus.spi_read   <= ~bus.req_write[pick];
                        bus.req_ready  <= One << pick;
                        state          <= StIssue;
                    end
                end
                StIssue: begin
                    start_cnt <= 8'(START_TMO);
                    state     <= StWaitStart;
                end
                StWaitStart: begin
                    if (bus.spi_busy) begin
                        state <= StWaitDone;
                    end else if (start_cnt <= 8'd1) begin
                        bus.rsp_valid <= One << grant;
                        bus.rsp_err   <= 1'b1;
                        state         <= StResp;
                    end else begin
                        start_cnt <= start_cnt - 8'd1;
                    end
                end
                StWaitDone: begin
                    if (!bus.spi_busy) begin
                        bus.rsp_data  <= bus.spi_dout;
                        bus.rsp_valid <= One << grant;
                        bus.rsp_err   <= 1'b0;
                        state         <= StResp;
                    end
                end
                StResp: begin
                    rr_ptr      <= wrap_idx(grant, 1);
                    bus.rsp_err <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.dev_cs = '1;
        if (state != StIdle) bus.dev_cs[grant] = bus.spi_cs;
    end
endmodule

// File: tb/tb_spi32_arbiter.sv
// Bench for spi32_arbiter: directed scenarios plus randomized transfers against a
// transaction-level round-robin model and a behavioural spi32 responder.
module tb_spi32_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi32_arbiter_if #(.NREQ(N)) bus ();

    spi32_arbiter #(.NREQ(N), .START_TMO(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        cmd_wr  [N];
    logic [1:0]  cmd_nb  [N];
    logic [31:0] cmd_dat [N];
    int          exp_ptr;
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_cmd(input int i);
        cmd_wr[i]  = 1'($urandom_range(0, 1));
        cmd_nb[i]  = 2'($urandom_range(0, 3));
        cmd_dat[i] = $urandom;
    endtask

    task automatic drive_cmds();
        for (int i = 0; i < N; i++) begin
            bus.req_write[i]            = cmd_wr[i];
            bus.req_nbytes[2*i +: 2]    = cmd_nb[i];
            bus.req_data[32*i +: 32]    = cmd_dat[i];
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_devcs(input int g, input logic cs);
        logic [31:0] v;
        v    = 32'((1 << N) - 1);
        v[g] = cs;
        return v;
    endfunction

    // One full transaction. delay = cycle after ISSUE at which the spi32 model raises busy
    // (0 = never, forcing a start timeout); len = number of busy cycles.
    task automatic do_txn(input logic [N-1:0] mask, input int delay, input int len);
        int          g;
        int          n;
        int          c;
        int          exp_c;
        logic        exp_wr;
        logic [1:0]  exp_nb;
        logic [31:0] exp_din;
        logic [31:0] fin;
        g       = rr_pick(mask, exp_ptr);
        exp_wr  = cmd_wr[g];
        exp_nb  = cmd_nb[g];
        exp_din = cmd_dat[g];
        bus.req_valid = mask;
        drive_cmds();
        #1;
        n = 0;
        do begin
            tick();
            n++;
            #1;
        end while (bus.req_ready == '0 && n < 20);
        check("accept_latency", 32'(n), 32'd1);
        check("req_ready", 32'(bus.req_ready), 32'(1) << g);
        check("spi_write", 32'(bus.spi_write), 32'(exp_wr));
        check("spi_read", 32'(bus.spi_read), 32'(!exp_wr));
        check("spi_din", bus.spi_din, exp_din);
        check("spi_nbytes", 32'(bus.spi_nbytes), 32'(exp_nb));
        // Winner moves on to a fresh command; the latched one must not change.
        new_cmd(g);
        bus.req_valid[g] = 1'($urandom_range(0, 1));
        drive_cmds();
        fin   = $urandom;
        exp_c = (delay == 0) ? TMO + 1 : delay + len + 1;
        c     = 0;
        do begin
            tick();
            c++;
            if (delay != 0 && c >= delay && c < delay + len) begin
                bus.spi_busy = 1'b1;
                bus.spi_cs   = 1'b0;
                bus.spi_dout = $urandom;
            end else begin
                bus.spi_busy = 1'b0;
                bus.spi_cs   = 1'b1;
                if (delay != 0 && c == delay + len) bus.spi_dout = fin;
            end
            #1;
            check("dev_cs", 32'(bus.dev_cs), exp_devcs(g, bus.spi_cs));
            check("din_stable", bus.spi_din, exp_din);
            check("nbytes_stable", 32'(bus.spi_nbytes), 32'(exp_nb));
            check("no_pulse", 32'({bus.spi_read, bus.spi_write, bus.req_ready}), 32'd0);
        end while (bus.rsp_valid == '0 && c < 40);
        check("rsp_cycle", 32'(c), 32'(exp_c));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << g);
        check("rsp_err", 32'(bus.rsp_err), 32'(delay == 0));
        if (delay != 0) exp_rdata = fin;
        check("rsp_data", bus.rsp_data, exp_rdata);
        exp_ptr = (g + 1) % N;
        tick();
        bus.spi_cs = 1'b0;
        #1;
        check("idle_dev_cs", 32'(bus.dev_cs), 32'((1 << N) - 1));
        check("rsp_pulse_end", 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("rsp_data_hold", bus.rsp_data, exp_rdata);
        bus.spi_cs = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.spi_busy  = 1'b0;
        bus.spi_cs    = 1'b1;
        bus.spi_dout  = '0;
        for (int i = 0; i < N; i++) new_cmd(i);
        drive_cmds();
        exp_ptr   = 0;
        exp_rdata = '0;
        repeat (2) tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_spi", 32'({bus.spi_read, bus.spi_write, bus.spi_nbytes}), 32'd0);
        check("rst_spi_din", bus.spi_din, 32'd0);
        check("rst_dev_cs", 32'(bus.dev_cs), 32'((1 << N) - 1));
        reset_n = 1'b1;
        tick();

        // Single read on requester 0.
        cmd_wr[0]  = 1'b0;
        cmd_nb[0]  = 2'd0;
        cmd_dat[0] = 32'hA500_0000;
        do_txn(4'b0001, 2, 3);

        // All requesters held: rotation 0..3 twice.
        for (int t = 0; t < 8; t++) do_txn(4'b1111, $urandom_range(1, TMO), $urandom_range(1, 4));

        // Pointer to 3, then 0101 must alternate 0,2,0.
        do_txn(4'b0100, 1, 1);
        for (int t = 0; t < 3; t++) do_txn(4'b0101, $urandom_range(1, TMO), 2);

        // Start timeout, then the latest legal busy start.
        do_txn(4'b0010, 0, 1);
        do_txn(4'b0010, TMO, 2);

        // Write of 3 bytes on requester 2.
        cmd_wr[2]  = 1'b1;
        cmd_nb[2]  = 2'd3;
        cmd_dat[2] = 32'hDEAD_BEEF;
        do_txn(4'b0100, 3, 4);

        // Reset while the transfer is in flight.
        bus.req_valid = 4'b0010;
        tick();
        tick();
        bus.req_valid = '0;
        tick();
        bus.spi_busy = 1'b1;
        bus.spi_cs   = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_pulses", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
        check("mid_rst_spi", 32'({bus.spi_read, bus.spi_write, bus.spi_nbytes}), 32'd0);
        check("mid_rst_spi_din", bus.spi_din, 32'd0);
        check("mid_rst_dev_cs", 32'(bus.dev_cs), 32'((1 << N) - 1));
        bus.spi_busy = 1'b0;
        bus.spi_cs   = 1'b1;
        tick();
        check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        reset_n   = 1'b1;
        exp_ptr   = 0;
        exp_rdata = '0;
        tick();
        do_txn(4'b1010, 2, 2);

        // Random traffic, including timeouts.
        for (int t = 0; t < 30; t++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            do_txn(m, $urandom_range(0, TMO), $urandom_range(1, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
